// File: rtl/cpu_types_pkg.sv
`default_nettype none
// ============================================================================
// cpu_types_pkg : shared control-bundle, ALU op and decode-queue types.
// Rev 1.0
// ============================================================================
package cpu_types_pkg;

    typedef enum logic [3:0] {
        ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR,
        ALU_NOR, ALU_SLT, ALU_SLTU, ALU_SLL, ALU_SRL
    } aluop_t;

    typedef struct packed {
        logic [1:0] jump;
        logic [1:0] branch;
        logic [1:0] regDst;
        logic [1:0] extender;
        aluop_t     aluOp;
        logic       aluSrc;
        logic       jal;
        logic       memRead;
        logic       memtoReg;
        logic       memWrite;
        logic       regWrite;
        logic       datomic;
        logic       halt;
    } ctrl_t;

    typedef enum logic [1:0] {RUN, DRAIN, HALTED} dq_state_t;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
        ctrl_t       ctrl;
        logic        illegal;
    } dq_entry_t;

    localparam logic [1:0] EXT_ZERO  = 2'd0;
    localparam logic [1:0] EXT_SIGN  = 2'd1;
    localparam logic [1:0] EXT_UPPER = 2'd2;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_SLTIU = 6'h0B;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_XORI  = 6'h0E;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_LL    = 6'h30;
    localparam logic [5:0] OP_SC    = 6'h38;
    localparam logic [5:0] OP_HALT  = 6'h3F;

    localparam logic [5:0] FN_SLL  = 6'h00;
    localparam logic [5:0] FN_SRL  = 6'h02;
    localparam logic [5:0] FN_JR   = 6'h08;
    localparam logic [5:0] FN_ADD  = 6'h20;
    localparam logic [5:0] FN_ADDU = 6'h21;
    localparam logic [5:0] FN_SUB  = 6'h22;
    localparam logic [5:0] FN_SUBU = 6'h23;
    localparam logic [5:0] FN_AND  = 6'h24;
    localparam logic [5:0] FN_OR   = 6'h25;
    localparam logic [5:0] FN_XOR  = 6'h26;
    localparam logic [5:0] FN_NOR  = 6'h27;
    localparam logic [5:0] FN_SLT  = 6'h2A;
    localparam logic [5:0] FN_SLTU = 6'h2B;

    function automatic ctrl_t default_ctrl();
        ctrl_t c;
        c          = '0;
        c.aluSrc   = 1'b1;
        c.regWrite = 1'b1;
        c.extender = EXT_SIGN;
        c.regDst   = 2'd1;
        c.aluOp    = ALU_ADD;
        return c;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ctrl_decode.sv
`default_nettype none
// ============================================================================
// ctrl_decode : combinational MIPS word -> control bundle + illegal flag.
// Rev 1.0
// ============================================================================
module ctrl_decode
    import cpu_types_pkg::*;
#(
    parameter bit ATOMIC_EN    = 1'b1,
    parameter bit ILLEGAL_TRAP = 1'b1
) (
    input  logic [31:0] instr_i,
    output ctrl_t       ctrl_o,
    output logic        illegal_o
);

    logic [5:0] w_op;
    logic [5:0] w_fn;
    ctrl_t      w_c;
    logic       w_known;

    assign w_op = instr_i[31:26];
    assign w_fn = instr_i[5:0];

    always_comb begin
        w_c     = default_ctrl();
        w_known = 1'b1;
        case (w_op)
            OP_RTYPE: begin
                w_c.regDst = 2'd0;
                w_c.aluSrc = 1'b0;
                case (w_fn)
                    FN_SLL:          begin w_c.aluOp = ALU_SLL; w_c.regWrite = 1'b0; end
                    FN_SRL:          w_c.aluOp = ALU_SRL;
                    FN_JR:           begin w_c.jump = 2'd2; w_c.regWrite = 1'b0; end
                    FN_ADD, FN_ADDU: w_c.aluOp = ALU_ADD;
                    FN_SUB, FN_SUBU: w_c.aluOp = ALU_SUB;
                    FN_AND:          w_c.aluOp = ALU_AND;
                    FN_OR:           w_c.aluOp = ALU_OR;
                    FN_XOR:          w_c.aluOp = ALU_XOR;
                    FN_NOR:          w_c.aluOp = ALU_NOR;
                    FN_SLT:          w_c.aluOp = ALU_SLT;
                    FN_SLTU:         w_c.aluOp = ALU_SLTU;
                    default:         w_known = 1'b0;
                endcase
            end
            OP_J:             w_c.jump = 2'd1;
            OP_JAL:           begin w_c.jump = 2'd1; w_c.jal = 1'b1; w_c.regDst = 2'd2; end
            OP_BEQ:           begin w_c.branch = 2'd1; w_c.aluSrc = 1'b0; w_c.regWrite = 1'b0; w_c.aluOp = ALU_SUB; end
            OP_BNE:           begin w_c.branch = 2'd2; w_c.aluSrc = 1'b0; w_c.regWrite = 1'b0; w_c.aluOp = ALU_SUB; end
            OP_ADDI, OP_ADDIU: w_c.aluOp = ALU_ADD;
            OP_SLTI:          w_c.aluOp = ALU_SLT;
            OP_SLTIU:         w_c.aluOp = ALU_SLTU;
            OP_ANDI:          begin w_c.aluOp = ALU_AND; w_c.extender = EXT_ZERO; end
            OP_ORI:           begin w_c.aluOp = ALU_OR;  w_c.extender = EXT_ZERO; end
            OP_XORI:          begin w_c.aluOp = ALU_XOR; w_c.extender = EXT_ZERO; end
            OP_LUI:           w_c.extender = EXT_UPPER;
            OP_LW:            begin w_c.memRead = 1'b1; w_c.memtoReg = 1'b1; end
            OP_SW:            begin w_c.memWrite = 1'b1; w_c.regWrite = 1'b0; end
            OP_LL: begin
                if (ATOMIC_EN) begin
                    w_c.memRead  = 1'b1;
                    w_c.memtoReg = 1'b1;
                    w_c.datomic  = 1'b1;
                end else begin
                    w_known = 1'b0;
                end
            end
            OP_SC: begin
                // SC writes its success flag back, hence memtoReg with regWrite kept.
                if (ATOMIC_EN) begin
                    w_c.memWrite = 1'b1;
                    w_c.memtoReg = 1'b1;
                    w_c.datomic  = 1'b1;
                end else begin
                    w_known = 1'b0;
                end
            end
            OP_HALT:          w_c.halt = 1'b1;
            default:          w_known = 1'b0;
        endcase

        if (instr_i == 32'h0000_0000) begin
            w_c.regWrite = 1'b0;
        end
        if (!w_known) begin
            w_c = default_ctrl();
        end
        if (!w_known && ILLEGAL_TRAP) begin
            w_c.regWrite = 1'b0;
            w_c.memRead  = 1'b0;
            w_c.memWrite = 1'b0;
            w_c.jump     = 2'd0;
            w_c.branch   = 2'd0;
            w_c.halt     = 1'b0;
            w_c.datomic  = 1'b0;
        end
    end

    assign ctrl_o    = w_c;
    assign illegal_o = !w_known && ILLEGAL_TRAP;

endmodule
`default_nettype wire

// File: rtl/decode_ctrl_pipe.sv
`default_nettype none
// ============================================================================
// decode_ctrl_pipe : decoded-instruction queue with halt drain, LL/SC tracking
// and flush, between fetch and register read.  Rev 1.0
// ============================================================================
module decode_ctrl_pipe
    import cpu_types_pkg::*;
#(
    parameter int DEPTH        = 2,
    parameter bit ATOMIC_EN    = 1'b1,
    parameter bit ILLEGAL_TRAP = 1'b1
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_instr,
    input  logic [31:0] in_pc,
    input  logic        flush,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic [31:0] out_pc,
    output ctrl_t       out_ctrl,
    output logic        out_illegal,
    output logic        halted,
    output logic        atomic_pending
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    typedef logic [PTR_W-1:0] ptr_t;

    dq_entry_t        mem_q [DEPTH];
    ptr_t             head_q, head_d;
    ptr_t             tail_q, tail_d;
    logic [CNT_W-1:0] count_q, count_d;
    dq_state_t        state_q, state_d;
    logic             pend_q, pend_d;

    ctrl_t     w_dec_ctrl;
    logic      w_dec_illegal;
    dq_entry_t w_head;
    logic      w_empty, w_full, w_push, w_pop;

    function automatic ptr_t ptr_inc(input ptr_t p);
        return (p == ptr_t'(DEPTH - 1)) ? '0 : p + ptr_t'(1);
    endfunction

    ctrl_decode #(
        .ATOMIC_EN    (ATOMIC_EN),
        .ILLEGAL_TRAP (ILLEGAL_TRAP)
    ) u_ctrl_decode (
        .instr_i   (in_instr),
        .ctrl_o    (w_dec_ctrl),
        .illegal_o (w_dec_illegal)
    );

    assign w_empty   = (count_q == '0);
    assign w_full    = (count_q == CNT_W'(DEPTH));
    assign w_head    = mem_q[head_q];
    assign in_ready  = !RST && !flush && !w_full && (state_q == RUN);
    assign out_valid = !w_empty && !flush && (state_q != HALTED);
    assign w_push    = in_valid && in_ready;
    assign w_pop     = out_valid && out_ready;

    assign out_instr      = w_empty ? '0 : w_head.instr;
    assign out_pc         = w_empty ? '0 : w_head.pc;
    assign out_ctrl       = w_empty ? '0 : w_head.ctrl;
    assign out_illegal    = w_empty ? 1'b0 : w_head.illegal;
    assign halted         = (state_q == HALTED);
    assign atomic_pending = pend_q;

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        state_d = state_q;
        pend_d  = pend_q;
        if (flush && state_q != HALTED) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
            state_d = RUN;
            pend_d  = 1'b0;
        end else begin
            if (w_push) tail_d = ptr_inc(tail_q);
            if (w_pop)  head_d = ptr_inc(head_q);
            if (w_push && !w_pop)      count_d = count_q + CNT_W'(1);
            else if (w_pop && !w_push) count_d = count_q - CNT_W'(1);
            if (w_push && w_dec_ctrl.halt)  state_d = DRAIN;
            if (w_pop && w_head.ctrl.halt)  state_d = HALTED;
            // LL sets, SC clears; an SC with nothing pending leaves the flag at 0.
            if (w_pop && w_head.ctrl.datomic) pend_d = w_head.ctrl.memRead;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            state_q <= RUN;
            pend_q  <= 1'b0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            state_q <= state_d;
            pend_q  <= pend_d;
        end
    end

    always_ff @(posedge CLK) begin
        if (w_push) begin
            mem_q[tail_q] <= '{instr: in_instr, pc: in_pc, ctrl: w_dec_ctrl, illegal: w_dec_illegal};
        end
    end

endmodule
`default_nettype wire
